// File: rtl/ibus_sramlike_axi_if.sv
// Bus bundle for the instruction-side bridge: CPU sram_like fetch port plus AXI AR/R channels.
// "master" is the bridge's view, "slave" is the environment (fetch unit and AXI slave).
interface ibus_sramlike_axi_if #(
  parameter int ID_W = 4
);
  logic            inst_req;
  logic            inst_wr;
  logic [1:0]      inst_size;
  logic [31:0]     inst_addr;
  logic [31:0]     inst_wdata;
  logic [31:0]     inst_rdata;
  logic            inst_addr_ok;
  logic            inst_data_ok;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic [1:0]      arlock;
  logic [3:0]      arcache;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/ibus_sramlike_axi.sv
// Instruction-side sram_like to AXI read bridge; one single-beat read in flight at a time.
//   state | meaning
//   IDLE  | no fetch outstanding, waiting for inst_req
//   AR    | address held on AR channel until arready
//   R     | waiting for the read beat; rready high
module ibus_sramlike_axi #(
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] ARID_VAL = '0
) (
  input  logic                clock,
  input  logic                reset,
  ibus_sramlike_axi_if.master bus,
  output logic                bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] araddr_q;
  logic [1:0]  size_q;
  logic        arvalid_q;
  logic        capture;
  logic        ar_done;
  logic        r_done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      size_q    <= '0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        araddr_q <= bus.inst_addr;
        size_q   <= bus.inst_size;
      end
      if (capture) arvalid_q <= 1'b1;
      else if (ar_done) arvalid_q <= 1'b0;
      if (r_done && (bus.rresp != 2'b00)) bus_err <= 1'b1;
    end
  end

  // Any beat completes the fetch: arlen is fixed at 0, so rlast carries no extra information.
  always_comb begin
    state_nxt        = state;
    capture          = 1'b0;
    ar_done          = 1'b0;
    r_done           = 1'b0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    bus.rready       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.inst_req) begin
          capture   = 1'b1;
          state_nxt = AR;
        end
      end
      AR: begin
        bus.inst_addr_ok = bus.arready;
        if (bus.arready) begin
          ar_done   = 1'b1;
          state_nxt = R;
        end
      end
      R: begin
        bus.rready = 1'b1;
        if (bus.rvalid) begin
          r_done           = 1'b1;
          bus.inst_data_ok = 1'b1;
          bus.inst_rdata   = bus.rdata;
          state_nxt        = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.arid    = ARID_VAL;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = 8'd0;
  assign bus.arsize  = {1'b0, size_q};
  assign bus.arburst = 2'b01;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = arvalid_q;

  // Write side and response ID are intentionally dropped; this is a read-only fetch path.
  logic unused_ok;
  assign unused_ok = ^{bus.inst_wr, bus.inst_wdata, bus.rid, bus.rlast};

endmodule

// File: tb/tb_ibus_sramlike_axi.sv
// Self-checking bench for ibus_sramlike_axi: directed fetch scenarios, then a random CPU/AXI-slave pair.
module tb_ibus_sramlike_axi;
  localparam int ID_W = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bus_err;
  int   vec = 0;
  int   err = 0;
  bit   chk_en = 1'b0;
  bit   rnd = 1'b0;

  ibus_sramlike_axi_if #(.ID_W(ID_W)) bus ();

  ibus_sramlike_axi #(.ID_W(ID_W), .ARID_VAL(4'd0)) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memf(logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Transaction-level reference: is a fetch captured, has its address been accepted, sticky error.
  bit          m_busy, m_acc, m_err;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  always @(posedge clock) begin
    if (reset) begin
      m_busy = 0; m_acc = 0; m_err = 0; m_addr = '0; m_size = '0;
    end else if (!m_busy) begin
      if (bus.inst_req) begin
        m_busy = 1; m_acc = 0; m_addr = bus.inst_addr; m_size = bus.inst_size;
      end
    end else if (!m_acc) begin
      if (bus.arready) m_acc = 1;
    end else if (bus.rvalid) begin
      m_busy = 0;
      if (bus.rresp != 2'b00) m_err = 1;
    end
  end

  bit          f_addr_ok, f_data_ok, f_ar, f_r;
  logic [31:0] f_araddr;
  logic [31:0] cpu_addr;
  int          n_ar = 0, n_r = 0;

  always @(negedge clock) begin
    f_addr_ok = bus.inst_addr_ok;
    f_data_ok = bus.inst_data_ok;
    f_ar      = bus.arvalid && bus.arready;
    f_r       = bus.rvalid && bus.rready;
    f_araddr  = bus.araddr;
    if (chk_en) begin
      chk("arvalid", bus.arvalid, m_busy && !m_acc);
      chk("addr_ok", bus.inst_addr_ok, m_busy && !m_acc && bus.arready);
      chk("rready", bus.rready, m_busy && m_acc);
      chk("data_ok", bus.inst_data_ok, m_busy && m_acc && bus.rvalid);
      chk("inst_rdata", bus.inst_rdata, (m_busy && m_acc && bus.rvalid) ? bus.rdata : 32'h0);
      chk("araddr", bus.araddr, m_addr);
      chk("arsize", bus.arsize, {1'b0, m_size});
      chk("arlen", bus.arlen, 32'd0);
      chk("arburst", bus.arburst, 32'd1);
      chk("arid", bus.arid, 32'd0);
      chk("arlock_cache_prot", {bus.arlock, bus.arcache, bus.arprot}, 32'd0);
      chk("bus_err", bus_err, m_err);
      if (f_ar) n_ar++;
      if (f_r) n_r++;
      chk("outstanding_le1", (n_ar - n_r) <= 1, 32'd1);
      if (rnd && bus.inst_data_ok) chk("fetch_data", bus.inst_rdata, memf(cpu_addr));
    end
  end

  int          cpu_st = 0, gap = 0, issued = 0, done = 0;
  bit          spend = 1'b0;
  logic [31:0] saddr;
  int          rdly = 0;

  initial begin
    bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 0; bus.inst_addr = 0; bus.inst_wdata = 0;
    bus.arready = 0; bus.rid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rvalid = 0;
    tick(); tick();
    chk_en = 1;
    reset = 0;
    #1;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_rready", bus.rready, 0);

    // zero-wait fetch
    bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0000; bus.inst_size = 2; bus.arready = 1;
    #1 chk("t1_idle_addr_ok", bus.inst_addr_ok, 0);
    tick(); #1;
    chk("t1_arvalid", bus.arvalid, 1);
    chk("t1_araddr", bus.araddr, 32'hBFC0_0000);
    chk("t1_arsize", bus.arsize, 3'b010);
    chk("t1_arlen", bus.arlen, 0);
    chk("t1_addr_ok", bus.inst_addr_ok, 1);
    tick();
    bus.inst_req = 0; bus.arready = 0;
    bus.rvalid = 1; bus.rlast = 1; bus.rdata = 32'h3C1D_BFC0; bus.rresp = 0;
    #1;
    chk("t1_data_ok", bus.inst_data_ok, 1);
    chk("t1_rdata", bus.inst_rdata, 32'h3C1D_BFC0);
    tick();
    bus.rvalid = 0; bus.rlast = 0;
    #1;
    chk("t1_done_data_ok", bus.inst_data_ok, 0);
    chk("t1_done_rready", bus.rready, 0);

    // arready and rvalid together in AR: beat is taken in R next cycle
    bus.inst_req = 1; bus.inst_addr = 32'h0000_2000; bus.inst_size = 1;
    tick();
    bus.arready = 1; bus.rvalid = 1; bus.rlast = 1; bus.rdata = 32'h1234_5678;
    #1;
    chk("t7_addr_ok", bus.inst_addr_ok, 1);
    chk("t7_rready_ar", bus.rready, 0);
    chk("t7_data_ok_ar", bus.inst_data_ok, 0);
    tick();
    bus.inst_req = 0; bus.arready = 0;
    #1;
    chk("t7_data_ok_r", bus.inst_data_ok, 1);
    chk("t7_rdata", bus.inst_rdata, 32'h1234_5678);
    tick();
    bus.rvalid = 0; bus.rlast = 0;

    // error response
    bus.inst_req = 1; bus.inst_addr = 32'h0000_3000; bus.inst_size = 2;
    tick();
    bus.arready = 1;
    tick();
    bus.inst_req = 0; bus.arready = 0;
    bus.rvalid = 1; bus.rlast = 1; bus.rresp = 2'b10; bus.rdata = 32'hCAFE_0001;
    #1;
    chk("t5_data_ok", bus.inst_data_ok, 1);
    chk("t5_err_before", bus_err, 0);
    tick();
    bus.rvalid = 0; bus.rlast = 0; bus.rresp = 0;
    #1 chk("t5_err_set", bus_err, 1);
    bus.inst_req = 1; bus.inst_addr = 32'h0000_3004;
    tick();
    bus.arready = 1;
    tick();
    bus.inst_req = 0; bus.arready = 0; bus.rvalid = 1; bus.rlast = 1;
    tick();
    bus.rvalid = 0; bus.rlast = 0;
    #1 chk("t5_err_sticky", bus_err, 1);

    // reset while waiting in R
    bus.inst_req = 1; bus.inst_addr = 32'h0000_4000;
    tick();
    bus.arready = 1;
    tick();
    bus.inst_req = 0; bus.arready = 0;
    #1 chk("t6_rready_in_r", bus.rready, 1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("t6_arvalid", bus.arvalid, 0);
    chk("t6_rready", bus.rready, 0);
    chk("t6_addr_ok", bus.inst_addr_ok, 0);
    chk("t6_data_ok", bus.inst_data_ok, 0);
    chk("t6_bus_err", bus_err, 0);
    chk("t6_araddr", bus.araddr, 0);
    n_ar = 0; n_r = 0;

    // random fetch unit against a random single-beat AXI slave
    rnd = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (f_r) begin
        bus.rvalid = 0; bus.rlast = 0; spend = 0;
      end
      if (f_ar) begin
        spend = 1; saddr = f_araddr; rdly = $urandom_range(0, 7);
      end
      bus.arready = ($urandom_range(0, 2) == 0);
      if (spend && !bus.rvalid) begin
        if (rdly == 0) begin
          bus.rvalid = 1; bus.rlast = 1; bus.rdata = memf(saddr);
          bus.rresp = ($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
          bus.rid = ID_W'($urandom_range(0, 15));
        end else begin
          rdly--;
        end
      end
      if (!bus.rvalid) begin
        bus.rdata = 32'($urandom);
        bus.rresp = 2'($urandom_range(0, 3));
      end
      case (cpu_st)
        0: if (issued < 40) begin
          if (gap > 0) gap--;
          else begin
            bus.inst_req   = 1;
            bus.inst_size  = 2'($urandom_range(0, 2));
            bus.inst_addr  = (issued < 3) ? 32'h1000 + 32'(4 * issued) : (32'($urandom) & 32'hFFFF_FFFC);
            bus.inst_wr    = 1'($urandom_range(0, 1));
            bus.inst_wdata = 32'($urandom);
            cpu_addr       = bus.inst_addr;
            cpu_st         = 1;
            issued++;
          end
        end
        1: if (f_addr_ok) begin
          bus.inst_req  = 0;
          bus.inst_addr = 32'($urandom);
          cpu_st        = 2;
        end
        default: if (f_data_ok) begin
          done++;
          cpu_st = 0;
          gap    = $urandom_range(0, 3);
        end
      endcase
      if (issued == 40 && cpu_st == 0 && !spend) break;
    end
    chk("random_fetches_done", done, 40);
    chk("random_ar_count", n_ar, 40);
    tick(); tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
